cory_routen: RTL and testbench

Parametrised successor to the fixed 16×16 router: a crossbar of A valid/ready input channels to Z valid/ready output channels.
- Each output selects one input; several outputs may select the same input, which forks (broadcasts) it.
- Every output has a 2-entry buffer, so output backpressure is registered rather than combinational.
- Routing is reconfigured through a load strobe; the new table takes effect only after in-flight data has drained.
- It sits between cory_master-style producers and cory_slave-style consumers.

---
 rtl/cory_pkg.sv | 24 ++
 rtl/cory_fifo2.sv | 58 +++++
 rtl/cory_routen.sv | 175 +++++++++++++++++
 tb/tb_cory_routen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cory_pkg.sv
// rtl/cory_pkg.sv - shared types, constants and helpers for the cory_routen crossbar
package cory_pkg;

    localparam int DROP_W = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } cfg_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int reset_sel(input int z, input int a);
        return z % a;
    endfunction

endpackage

// File: rtl/cory_fifo2.sv
// rtl/cory_fifo2.sv - 2-entry output buffer with registered occupancy
module cory_fifo2 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [N-1:0] i_d,
    input  logic         i_pop,
    output logic         o_v,
    output logic [N-1:0] o_d,
    output logic [1:0]   o_cnt
);

    logic [N-1:0] r_q0;
    logic [N-1:0] r_q1;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop & (r_cnt != 2'd0);
    assign w_push = i_push & (r_cnt != 2'd2);

    // r_q0 is the head; it is left untouched when the last word pops so o_d holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_q0 <= i_d;
                    else               r_q1 <= i_d;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_cnt == 2'd2) r_q0 <= r_q1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_q0 <= i_d;
                    end else begin
                        r_q0 <= r_q1;
                        r_q1 <= i_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_v   = (r_cnt != 2'd0);
    assign o_d   = r_q0;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/cory_routen.sv
// rtl/cory_routen.sv - A-to-Z valid/ready crossbar with broadcast and drained reconfiguration
module cory_routen
    import cory_pkg::*;
#(
    parameter int N = 8,
    parameter int A = 16,
    parameter int Z = 16,
    parameter int S = clog2(A),
    parameter int D = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [A-1:0]      i_a_v,
    input  logic [A*N-1:0]    i_a_d,
    output logic [A-1:0]      o_a_r,
    output logic [Z-1:0]      o_z_v,
    output logic [Z*N-1:0]    o_z_d,
    input  logic [Z-1:0]      i_z_r,
    input  logic [Z*S-1:0]    i_z_s,
    input  logic [Z-1:0]      i_z_e,
    input  logic              i_cfg_ld,
    output logic              o_cfg_busy,
    output logic [DROP_W-1:0] o_drop_cnt
);

    localparam int AP = 2 ** S;

    cfg_state_t         r_state;
    cfg_state_t         w_state_nxt;
    logic               w_commit;
    logic [S-1:0]       r_sel    [Z];
    logic [Z-1:0]       r_en;
    logic [S-1:0]       r_sh_sel [Z];
    logic [Z-1:0]       r_sh_en;
    logic [DROP_W-1:0]  r_drop;

    logic [N-1:0]       w_in_d   [AP];
    logic [1:0]         w_cnt    [Z];
    logic [Z-1:0]       w_space;
    logic [Z-1:0]       w_push;
    logic [Z-1:0]       w_sub    [A];
    logic [A-1:0]       w_sub_any;
    logic [A-1:0]       w_sub_ok;
    logic [A-1:0]       w_xfer;
    logic [AP-1:0]      w_xfer_x;
    logic               w_all_empty;
    logic [DROP_W-1:0]  w_drop_n;
    logic [DROP_W:0]    w_drop_sum;

    // Pad the input data array to a power of two so any select value is a legal index
    for (genvar ga = 0; ga < AP; ga++) begin : g_in
        if (ga < A) begin : g_real
            assign w_in_d[ga] = i_a_d[ga*N +: N];
        end else begin : g_pad
            assign w_in_d[ga] = '0;
        end
    end

    always_comb begin
        w_sub_any = '0;
        w_sub_ok  = '1;
        for (int a = 0; a < A; a++) begin
            w_sub[a] = '0;
            for (int z = 0; z < Z; z++) begin
                if (r_en[z] && (r_sel[z] == S'(a))) begin
                    w_sub[a][z] = 1'b1;
                    w_sub_any[a] = 1'b1;
                    if (!w_space[z]) w_sub_ok[a] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_a_r = '0;
        if (r_state == ST_RUN) begin
            for (int a = 0; a < A; a++) begin
                o_a_r[a] = w_sub_any[a] ? w_sub_ok[a] : (D != 0);
            end
        end
    end

    assign w_xfer = i_a_v & o_a_r;

    always_comb begin
        w_xfer_x        = '0;
        w_xfer_x[A-1:0] = w_xfer;
    end

    for (genvar gz = 0; gz < Z; gz++) begin : g_out
        assign w_space[gz] = (w_cnt[gz] != 2'd2);
        assign w_push[gz]  = r_en[gz] & w_xfer_x[r_sel[gz]];

        cory_fifo2 #(.N(N)) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .i_push (w_push[gz]),
            .i_d    (w_in_d[r_sel[gz]]),
            .i_pop  (i_z_r[gz]),
            .o_v    (o_z_v[gz]),
            .o_d    (o_z_d[gz*N +: N]),
            .o_cnt  (w_cnt[gz])
        );
    end

    always_comb begin
        w_all_empty = 1'b1;
        for (int z = 0; z < Z; z++) begin
            if (w_cnt[z] != 2'd0) w_all_empty = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_cfg_ld) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!i_cfg_ld && w_all_empty) begin
                    w_state_nxt = ST_RUN;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    // Out-of-range selects become disabled outputs when the shadow is committed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int z = 0; z < Z; z++) begin
                r_sel[z]    <= S'(reset_sel(z, A));
                r_sh_sel[z] <= S'(reset_sel(z, A));
            end
            r_en    <= '1;
            r_sh_en <= '1;
        end else begin
            if (i_cfg_ld) begin
                for (int z = 0; z < Z; z++) r_sh_sel[z] <= i_z_s[z*S +: S];
                r_sh_en <= i_z_e;
            end
            if (w_commit) begin
                for (int z = 0; z < Z; z++) begin
                    r_sel[z] <= r_sh_sel[z];
                    r_en[z]  <= r_sh_en[z] & ({1'b0, r_sh_sel[z]} < (S+1)'(A));
                end
            end
        end
    end

    always_comb begin
        w_drop_n = '0;
        for (int a = 0; a < A; a++) begin
            w_drop_n = w_drop_n + DROP_W'(w_xfer[a] & ~w_sub_any[a]);
        end
        w_drop_sum = {1'b0, r_drop} + {1'b0, w_drop_n};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              r_drop <= '0;
        else if (w_drop_sum[DROP_W]) r_drop <= '1;
        else                    r_drop <= w_drop_sum[DROP_W-1:0];
    end

    assign o_cfg_busy = (r_state == ST_DRAIN);
    assign o_drop_cnt = (D != 0) ? r_drop : '0;

endmodule

// File: tb/tb_cory_routen.sv
// tb/tb_cory_routen.sv - scoreboard bench for cory_routen against a queue-based routing model
module tb_cory_routen;

    localparam int N = 8;
    localparam int A = 4;
    localparam int Z = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [A-1:0]   a_v;
    logic [A*N-1:0] a_d;
    logic [A-1:0]   a_r;
    logic [Z-1:0]   z_v;
    logic [Z*N-1:0] z_d;
    logic [Z-1:0]   z_r;
    logic [Z*S-1:0] z_s;
    logic [Z-1:0]   z_e;
    logic           cfg_ld;
    logic           busy;
    logic [15:0]    drop;

    logic [A-1:0]   d1_v;
    logic [A-1:0]   d1_a_r;
    logic [Z-1:0]   d1_z_v;
    logic [Z*N-1:0] d1_z_d;
    logic           d1_busy;
    logic [15:0]    d1_drop;

    always #5 clk = ~clk;

    cory_routen #(.N(N), .A(A), .Z(Z), .S(S), .D(0)) dut (
        .clk(clk), .reset(reset), .i_a_v(a_v), .i_a_d(a_d), .o_a_r(a_r),
        .o_z_v(z_v), .o_z_d(z_d), .i_z_r(z_r), .i_z_s(z_s), .i_z_e(z_e),
        .i_cfg_ld(cfg_ld), .o_cfg_busy(busy), .o_drop_cnt(drop)
    );

    cory_routen #(.N(N), .A(A), .Z(Z), .S(S), .D(1)) dut_sink (
        .clk(clk), .reset(reset), .i_a_v(d1_v), .i_a_d(a_d), .o_a_r(d1_a_r),
        .o_z_v(d1_z_v), .o_z_d(d1_z_d), .i_z_r(z_r), .i_z_s(z_s), .i_z_e(z_e),
        .i_cfg_ld(cfg_ld), .o_cfg_busy(d1_busy), .o_drop_cnt(d1_drop)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [N-1:0] q [Z][$];
    int           m_sel [Z];
    bit           m_en  [Z];
    int           sh_sel [Z];
    bit           sh_en  [Z];
    bit           m_drain = 1'b0;

    function automatic bit m_ready(input int a);
        bit any;
        bit ok;
        any = 1'b0;
        ok  = 1'b1;
        if (m_drain) return 1'b0;
        for (int z = 0; z < Z; z++) begin
            if (m_en[z] && m_sel[z] == a) begin
                any = 1'b1;
                if (q[z].size() >= 2) ok = 1'b0;
            end
        end
        return any ? ok : 1'b0;
    endfunction

    logic [A-1:0] exp_r;
    logic [Z-1:0] exp_v;
    bit           all_empty;

    always @(negedge clk) begin
        if (reset) begin
            for (int z = 0; z < Z; z++) begin
                q[z].delete();
                m_sel[z]  = z % A;
                m_en[z]   = 1'b1;
                sh_sel[z] = z % A;
                sh_en[z]  = 1'b1;
            end
            m_drain = 1'b0;
        end else begin
            all_empty = 1'b1;
            for (int z = 0; z < Z; z++) begin
                exp_v[z] = (q[z].size() != 0);
                if (q[z].size() != 0) all_empty = 1'b0;
            end
            for (int a = 0; a < A; a++) exp_r[a] = m_ready(a);
            check("a_ready", a_r, exp_r);
            check("z_valid", z_v, exp_v);
            check("cfg_busy", busy, m_drain);
            for (int z = 0; z < Z; z++) begin
                if (z_v[z] && z_r[z]) begin
                    if (q[z].size() == 0)
                        check($sformatf("z%0d_pending", z), 0, 1);
                    else
                        check($sformatf("z%0d_data", z), z_d[z*N +: N], q[z].pop_front());
                end
            end
            for (int a = 0; a < A; a++) begin
                if (a_v[a] && exp_r[a]) begin
                    for (int z = 0; z < Z; z++) begin
                        if (m_en[z] && m_sel[z] == a) q[z].push_back(a_d[a*N +: N]);
                    end
                end
            end
            if (cfg_ld) begin
                for (int z = 0; z < Z; z++) begin
                    sh_sel[z] = int'(z_s[z*S +: S]);
                    sh_en[z]  = z_e[z];
                end
                m_drain = 1'b1;
            end else if (m_drain && all_empty) begin
                for (int z = 0; z < Z; z++) begin
                    m_sel[z] = sh_sel[z];
                    m_en[z]  = sh_en[z] && (sh_sel[z] < A);
                end
                m_drain = 1'b0;
            end
        end
    end

    task automatic step(input logic [A-1:0] v, input logic [Z-1:0] r, input logic [A*N-1:0] d);
        @(posedge clk);
        #1;
        a_v    = v;
        z_r    = r;
        a_d    = d;
        cfg_ld = 1'b0;
    endtask

    task automatic rstep();
        step(A'($urandom), Z'($urandom), $urandom);
    endtask

    task automatic cfg(input logic [Z*S-1:0] s, input logic [Z-1:0] e);
        @(posedge clk);
        #1;
        a_d    = $urandom;
        z_s    = s;
        z_e    = e;
        cfg_ld = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_z_valid"}, z_v, '0);
        check({tag, "_z_data"}, z_d, '0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_a_ready"}, a_r, 4'hF);
        check({tag, "_drop"}, d1_drop, 0);
    endtask

    task automatic pulse_reset(input string tag);
        #1 reset = 1'b1;
        #1 check_reset_outputs(tag);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    localparam logic [Z*S-1:0] SEL_ID    = {2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [Z*S-1:0] SEL_REV   = {2'd0, 2'd1, 2'd2, 2'd3};
    localparam logic [Z*S-1:0] SEL_BCAST = {2'd0, 2'd2, 2'd2, 2'd2};
    localparam logic [Z*S-1:0] SEL_NO3   = {2'd0, 2'd2, 2'd1, 2'd0};

    initial begin
        int guard;
        reset  = 1'b1;
        a_v    = '0;
        d1_v   = '0;
        a_d    = '0;
        z_r    = '1;
        z_s    = '0;
        z_e    = '0;
        cfg_ld = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        check("reset_drop_d0", drop, 0);
        #1 reset = 1'b0;

        for (int k = 0; k < 16; k++) step('1, '1, {4{8'(k)}});

        for (int k = 0; k < 4; k++) step('1, 4'b1110, $urandom);
        repeat (6) step('1, '1, $urandom);

        repeat (150) rstep();

        cfg(SEL_BCAST, 4'hF);
        for (int k = 0; k < 60; k++)
            step(A'($urandom), {1'b1, 1'b1, (k % 3 == 0), 1'b1}, $urandom);

        cfg(SEL_ID, 4'hF);
        repeat (4) step('1, '0, $urandom);
        cfg(SEL_REV, 4'hF);
        z_r = '0;
        repeat (3) step('1, '0, $urandom);
        guard = 0;
        while (m_drain && guard < 100) begin
            step('1, Z'($urandom), $urandom);
            guard++;
        end
        check("drain_done", m_drain, 0);
        repeat (40) rstep();

        cfg(SEL_NO3, 4'hF);
        repeat (50) rstep();
        check("sink_drop_before", d1_drop, 0);
        for (int k = 0; k < 5; k++) begin
            rstep();
            d1_v = 4'b1000;
            #1 check("sink_ready3", d1_a_r[3], 1);
        end
        rstep();
        d1_v = '0;
        check("sink_drop_count", d1_drop, 5);

        for (int k = 0; k < 4; k++) begin
            cfg(Z*S'($urandom), Z'($urandom));
            repeat (40) rstep();
        end

        repeat (10) rstep();
        pulse_reset("reset_traffic");
        repeat (30) step(A'($urandom), '1, $urandom);

        repeat (3) step('1, '0, $urandom);
        cfg(SEL_REV, 4'hF);
        z_r = '0;
        step('1, '0, $urandom);
        check("busy_in_drain", busy, 1);
        pulse_reset("reset_drain");
        repeat (40) step(A'($urandom), '1, $urandom);

        check("drop_d0", drop, 0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
